// File: rtl/sender.sv
// sender: UART transmitter (8N1, LSB first) fed by the out-commit queue.
//
// A one-byte holding buffer lets the next byte be committed while the
// current frame is still shifting out. A frame that ends with the buffer
// full chains straight into the next start bit with no idle cycle.
//
// Optional feature: define SENDER_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit(s).
//
// Parameters:
//   CLK_PER_BIT  clock cycles per UART bit (>= 2)
//   N_STOP       number of stop bits (1 or 2)
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-low reset, synchronous release
//   ready  out  registered; holding buffer empty, byte accepted if valid
//   valid  in   upstream offers `in`
//   in     in   [7:0] byte to transmit, sampled on valid && ready
//   txd    out  registered serial line, idles high

module sender #(
    parameter int CLK_PER_BIT = 868,
    parameter int N_STOP      = 1
) (
    input  logic       clk,
    input  logic       reset,
    output logic       ready,
    input  logic       valid,
    input  logic [7:0] in,
    output logic       txd
);

    localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_PER_BIT - 1);
    localparam logic [2:0]    STOP_LAST = 3'(N_STOP - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef SENDER_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state;
    logic [7:0]    buf_data;
    logic          buf_valid;
    logic [7:0]    shreg;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
`ifdef SENDER_PARITY_EN
    logic          parity;
`endif

    logic accept;
    logic bit_end;
    logic load;
    logic buf_valid_nxt;

    // ready is registered from the next buffer state, so it never depends
    // combinationally on valid. accept and load are mutually exclusive:
    // accept needs an empty buffer, load needs a full one.
    always_comb begin
        accept        = valid && ready;
        bit_end       = (baud_cnt == BAUD_LAST);
        load          = buf_valid &&
                        ((state == IDLE) ||
                         (state == STOP && bit_end && bit_cnt == STOP_LAST));
        buf_valid_nxt = buf_valid;
        if (load)
            buf_valid_nxt = 1'b0;
        else if (accept)
            buf_valid_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ready     <= 1'b0;
            txd       <= 1'b1;
            buf_data  <= '0;
            buf_valid <= 1'b0;
            shreg     <= '0;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
`ifdef SENDER_PARITY_EN
            parity    <= 1'b0;
`endif
        end else begin
            buf_valid <= buf_valid_nxt;
            ready     <= !buf_valid_nxt;
            if (accept)
                buf_data <= in;

            case (state)
                IDLE: begin
                    txd      <= 1'b1;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (load) begin
                        shreg  <= buf_data;
`ifdef SENDER_PARITY_EN
                        parity <= ^buf_data;
`endif
                        txd    <= 1'b0;
                        state  <= START;
                    end
                end

                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        txd      <= shreg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
`ifdef SENDER_PARITY_EN
                            txd     <= parity;
                            state   <= PARITY;
`else
                            txd     <= 1'b1;
                            state   <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            // next bit is presented together with the shift
                            txd     <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end

`ifdef SENDER_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        txd      <= 1'b1;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
`endif

                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            // a buffered byte chains directly into its start bit
                            if (load) begin
                                shreg  <= buf_data;
`ifdef SENDER_PARITY_EN
                                parity <= ^buf_data;
`endif
                                txd    <= 1'b0;
                                state  <= START;
                            end else begin
                                txd    <= 1'b1;
                                state  <= IDLE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end

                default: begin
                    txd   <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sender.sv
// tb_sender: randomized + directed bench for sender. A timeline model
// predicts ready and txd every cycle; a line decoder recovers bytes from
// txd and matches them against the accepted-byte order.

`timescale 1ns/1ps

module tb_sender;

    localparam int C  = 4;
    localparam int NS = 1;
`ifdef SENDER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME = (10 + NS - 1 + PAR) * C;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] in    = '0;
    logic       ready;
    logic       txd;

    always #5 clk = ~clk;

    sender #(.CLK_PER_BIT(C), .N_STOP(NS)) dut (
        .clk   (clk),
        .reset (reset),
        .ready (ready),
        .valid (valid),
        .in    (in),
        .txd   (txd)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit chk_en   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model: frames on a timeline ----------------
    typedef struct {
        int         start;
        logic [7:0] data;
    } frame_t;

    frame_t     frames[$];
    logic [7:0] exp_q[$];
    bit         m_up      = 0;
    bit         m_ready   = 0;
    int         line_free = 0;
    int         buf_start = 0;
    int         n_acc     = 0;
    int         acc_last  = 0;

    // txd level after edge t: start 0, data LSB first, optional parity, stops 1
    function automatic logic exp_txd(input int t);
        int idx;
        exp_txd = 1'b1;
        foreach (frames[i]) begin
            if (t >= frames[i].start && t < frames[i].start + FRAME) begin
                idx = (t - frames[i].start) / C;
                if (idx == 0)
                    exp_txd = 1'b0;
                else if (idx <= 8)
                    exp_txd = frames[i].data[idx-1];
                else if (PAR == 1 && idx == 9)
                    exp_txd = ^frames[i].data;
                else
                    exp_txd = 1'b1;
            end
        end
    endfunction

    always @(negedge reset) begin
        m_up    = 0;
        m_ready = 0;
        frames.delete();
        exp_q.delete();
    end

    always @(posedge clk) begin
        frame_t f;
        cyc++;
        if (!reset) begin
            m_up    = 0;
            m_ready = 0;
            frames.delete();
            exp_q.delete();
        end else if (!m_up) begin
            m_up      = 1;
            m_ready   = 1;
            line_free = cyc;
            buf_start = cyc;
        end else begin
            if (valid && m_ready) begin
                f.start = (cyc + 1 > line_free) ? cyc + 1 : line_free;
                f.data  = in;
                frames.push_back(f);
                exp_q.push_back(in);
                line_free = f.start + FRAME;
                buf_start = f.start;
                n_acc++;
                acc_last = cyc;
            end
            m_ready = (cyc >= buf_start);
            while (frames.size() > 0 && cyc >= frames[0].start + FRAME)
                void'(frames.pop_front());
        end
    end

    // ---------------- per-cycle compare + line decoder ----------------
    bit         rx_busy  = 0;
    int         rx_k     = 0;
    logic [7:0] rx_byte  = '0;
    int         rx_count = 0;
    int         rx_start_q[$];

    always @(negedge clk) begin
        int j;
        if (chk_en) begin
            check_eq("txd", txd, exp_txd(cyc));
            check_eq("ready", ready, m_ready);
        end
        if (!reset) begin
            rx_busy = 0;
        end else if (!rx_busy) begin
            if (txd === 1'b0) begin
                rx_busy = 1;
                rx_k    = 0;
                rx_start_q.push_back(cyc);
            end
        end else begin
            rx_k++;
        end
        if (rx_busy && reset) begin
            if (rx_k % C == C / 2) begin
                j = rx_k / C;
                if (j == 0)
                    check_eq("rx_start", txd, 1'b0);
                else if (j <= 8)
                    rx_byte[j-1] = txd;
                else if (PAR == 1 && j == 9)
                    check_eq("rx_parity", txd, ^rx_byte);
                else
                    check_eq("rx_stop", txd, 1'b1);
            end
            if (rx_k == FRAME - 1) begin
                rx_busy = 0;
                rx_count++;
                if (exp_q.size() > 0)
                    check_eq("rx_byte", rx_byte, exp_q.pop_front());
                else
                    check_eq("rx_extra", exp_q.size(), 1);
            end
        end
    end

    // ---------------- stimulus ----------------
    // Offer d with valid high until the model accepts it; in is scrambled
    // whenever the buffer is full to show it is ignored.
    task automatic offer(input logic [7:0] d);
        int n0 = n_acc;
        int k  = 0;
        valid = 1'b1;
        while (n_acc == n0 && k < 400) begin
            in = m_ready ? d : 8'($urandom);
            @(negedge clk);
            k++;
        end
        if (n_acc == n0)
            check_eq("accept_timeout", n_acc, n0 + 1);
    endtask

    task automatic drain();
        int k = 0;
        valid = 1'b0;
        while (!(frames.size() == 0 && m_ready && !rx_busy) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000)
            check_eq("drain_timeout", k, 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int s;
        int k;
        int rxc0;
        int acc0;

        #1 reset = 1'b0;
        #1 chk_en = 1;
        repeat (3) @(negedge clk);
        check_eq("rst_txd", txd, 1'b1);
        check_eq("rst_ready", ready, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_eq("ready_after_release", ready, 1'b1);

        // single byte
        offer(8'h55);
        drain();
        check_eq("single_count", rx_count, 1);
        check_eq("single_latency", rx_start_q[$] - acc_last, 1);

        // back-to-back, valid held
        offer(8'hA5);
        offer(8'h3C);
        drain();
        check_eq("b2b_count", rx_count, 3);
        check_eq("b2b_contig", rx_start_q[$] - rx_start_q[$-1], FRAME);

        // three bytes with valid held throughout
        offer(8'h11);
        offer(8'h22);
        offer(8'h33);
        drain();
        check_eq("hold_count", rx_count, 6);
        check_eq("hold_contig1", rx_start_q[$-1] - rx_start_q[$-2], FRAME);
        check_eq("hold_contig2", rx_start_q[$] - rx_start_q[$-1], FRAME);

        // reset in data bit 3 with a second byte buffered
        offer(8'hF0);
        s = acc_last + 1;
        offer(8'h99);
        valid = 1'b0;
        k = 0;
        while (cyc < s + 4 * C + 1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_eq("reach_data3", (cyc >= s + 4 * C + 1), 1'b1);
        rxc0 = rx_count;
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check_eq("async_txd", txd, 1'b1);
        check_eq("async_ready", ready, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rel_ready", ready, 1'b1);
        repeat (60) @(negedge clk);
        check_eq("abandon_count", rx_count, rxc0);

        // randomized traffic
        acc0 = n_acc;
        rxc0 = rx_count;
        for (int i = 0; i < 600; i++) begin
            valid = ($urandom % 3 == 0);
            in    = 8'($urandom);
            @(negedge clk);
        end
        drain();
        check_eq("rand_count", rx_count - rxc0, n_acc - acc0);
        check_eq("final_txd", txd, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

endmodule

// File: doc/sender.md
Name: sender

Overview:
- UART transmitter that serialises bytes handed over by the output-commit unit onto the `txd` line.
- Sits directly downstream of the out-commit queue. Its `ready`, `valid` and `in` ports connect to that unit's `sender_ready`, `sender_valid` and `sender_in`.
- Has a one-byte holding buffer, so the next byte can be committed while the current frame is still shifting out.
- Frame format: 8N1, LSB first, fixed baud set by a cycle count.

Parameters:
- CLK_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200). Legal range is 2 or more.
- N_STOP, 1, number of stop bits. Legal values are 1 or 2.

Ports:
- clk  input  1  system clock. All logic is on the rising edge.
- reset  input  1  asynchronous, active-low reset. Asserting (driving 0) clears all state immediately. Release is synchronous to clk.
- ready  output  1  registered. High means the holding buffer is empty and a byte is accepted this cycle if valid is high.
- valid  input  1  upstream offers `in`. May be asserted or dropped without regard to ready.
- in  input  8  byte to transmit. Sampled only on the accept edge (valid && ready).
- txd  output  1  serial line, registered. Idle level is 1.

Behaviour:
- Reset values: ready=0, txd=1, state=IDLE, buf_valid=0, baud counter=0, bit counter=0.
- ready rises on the first clock edge after reset is released.
- ready must not depend combinationally on valid, because upstream derives its commit from ready.
- Accept: on an edge where valid && ready, `in` is latched into buf and buf_valid is set.
  - ready is 0 from the next cycle onward.
  - Exactly one byte is taken per accept edge. No byte is duplicated or dropped.
- ready = !buf_valid, registered. It reasserts the cycle after the FSM moves buf into the shift register.
- FSM states: IDLE, START, DATA, PARITY (feature only), STOP.
  - IDLE: txd=1. If buf_valid, load shreg<=buf, clear buf_valid, go to START.
  - START: txd=0 for CLK_PER_BIT cycles, then go to DATA with bit count 0.
  - DATA: txd=shreg[0] for CLK_PER_BIT cycles, then shift right. After bit 7 go to PARITY or STOP.
  - STOP: txd=1 for N_STOP*CLK_PER_BIT cycles.
    - At the end, if buf_valid, load buf and go straight to START with no idle cycle.
    - Otherwise go to IDLE.
- Latency: the byte is accepted at edge E0, the FSM leaves IDLE at edge E1, and txd=0 from just after E1.
  - So the start bit begins 1 cycle after acceptance when the FSM is idle.
- Bit timing: a baud counter runs from 0 to CLK_PER_BIT-1, and the bit ends when it reaches CLK_PER_BIT-1.
  - The counter width is $clog2(CLK_PER_BIT).
  - Every bit lasts exactly CLK_PER_BIT cycles, with no accumulated drift.
- Frame length is (10 + N_STOP - 1) * CLK_PER_BIT cycles, plus CLK_PER_BIT when parity is enabled.
- Simultaneous events: an accept and the FSM's load of buf can fall on the same edge only if buf was empty. In that case buf is not loaded by the FSM, so there is no conflict.
- Buffer full: with valid held high and ready low, nothing changes. `in` is ignored.
- Reset mid-frame: txd goes to 1 asynchronously and the partial frame is abandoned.
  - The buffered byte is discarded.
  - Upstream flushes in step with the same reset.

Optional Feature:
- Macro: SENDER_PARITY_EN.
- Defined: after DATA, the PARITY state drives even parity (XOR of the 8 data bits) for CLK_PER_BIT cycles, then goes to STOP.
- Undefined: the PARITY state and its logic are absent, and DATA goes directly to STOP.

Test Plan:
- CLK_PER_BIT=4, N_STOP=1, reset released. Send 0x55 once.
  - ready=1 before the accept and 0 for one cycle after it.
  - txd = 0, then 1,0,1,0,1,0,1,0, then 1, with each level held 4 cycles. Total 40 cycles.
  - The start bit begins 1 cycle after the accept.
- Back-to-back: hold valid high with 0xA5 then 0x3C.
  - The second byte is accepted 2 cycles after the first.
  - The frames are contiguous over 80 cycles with no idle gap.
  - ready goes 0 → 1 exactly when frame 2's start bit begins.
- Hold: offer 0x11, 0x22, 0x33 with valid held high throughout.
  - Exactly three frames appear, in order, with no duplicates.
  - in is ignored while ready=0.
- Reset asserted in DATA bit 3 of 0xF0 with a second byte buffered.
  - txd=1 and ready=0 immediately.
  - After release, ready=1 next cycle, txd stays 1, and no frame is emitted.
- SENDER_PARITY_EN defined, send 0x07.
  - A parity bit of 1 appears after the data.
  - The frame is 44 cycles at CLK_PER_BIT=4.
- N_STOP=2, back-to-back 0x00, 0xFF: the stop high lasts 8 cycles between the frames.
